// File: rtl/serial_adder.sv
// Bit-serial add/subtract engine: one full-adder cell and a carry flop
// walk two WIDTH-bit operands LSB first, one bit per hz100 cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_nxt;
    logic             carry;
    logic [CW-1:0]    count;
    logic             s_bit;
    logic             c_bit;
    logic             last;

    always_comb begin
        s_bit = op_a[0] ^ op_b[0] ^ carry;
        c_bit = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
        last  = (count == CW'(WIDTH - 1));
    end

    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign shadow_nxt = s_bit;
        end else begin : g_wide
            assign shadow_nxt = {s_bit, shadow[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum    <= '0;
            co     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? ~ci : ci;
                        count <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    shadow <= shadow_nxt;
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= c_bit;
                    count  <= count + 1'b1;
                    // carry holds the carry into the MSB on the final bit
                    if (last) begin
                        sum   <= shadow_nxt;
                        co    <= c_bit;
                        ovf   <= carry ^ c_bit;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 main instance plus a
// WIDTH=1 instance sharing clock and reset.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       co;
        logic       ovf;
    } res_t;

    logic       hz100 = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       sub   = 1'b0;
    logic [7:0] a     = '0;
    logic [7:0] b     = '0;
    logic       ci    = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       co;
    logic       ovf;

    logic       start1 = 1'b0;
    logic       sub1   = 1'b0;
    logic [0:0] a1     = '0;
    logic [0:0] b1     = '0;
    logic       ci1    = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       co1;
    logic       ovf1;

    res_t       sb[$];
    logic [7:0] last_sum = '0;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;

    serial_adder #(.WIDTH(8)) u_dut (
        .hz100(hz100), .reset(reset), .start(start), .sub(sub),
        .a(a), .b(b), .ci(ci), .busy(busy), .done(done),
        .sum(sum), .co(co), .ovf(ovf)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .hz100(hz100), .reset(reset), .start(start1), .sub(sub1),
        .a(a1), .b(b1), .ci(ci1), .busy(busy1), .done(done1),
        .sum(sum1), .co(co1), .ovf(ovf1)
    );

    always #5 hz100 = ~hz100;

    always @(posedge hz100) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic mci, input logic msub);
        logic [7:0] bb;
        logic       cc;
        logic [8:0] f;
        res_t       r;
        bb    = msub ? ~mb : mb;
        cc    = msub ? ~mci : mci;
        f     = {1'b0, ma} + {1'b0, bb} + {8'd0, cc};
        r.sum = f[7:0];
        r.co  = f[8];
        r.ovf = (ma[7] == bb[7]) && (f[7] != ma[7]);
        return r;
    endfunction

    // Monitor: results are popped on done; sum must not move while busy.
    always @(negedge hz100) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("sum", sum, e.sum);
                check("co", co, e.co);
                check("ovf", ovf, e.ovf);
                last_sum = e.sum;
            end
        end else if (busy) begin
            check("sum_hold", sum, last_sum);
        end
    end

    task automatic wait_done(output bit seen, output int nbusy);
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge hz100);
        end
        if (!seen) check("timeout", 0, 1);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tci, input logic tsub);
        bit seen;
        int nb;
        @(negedge hz100);
        a = ta; b = tb_; ci = tci; sub = tsub; start = 1'b1;
        sb.push_back(model(ta, tb_, tci, tsub));
        @(negedge hz100);
        start = 1'b0;
        a = ~ta; b = ~tb_; ci = ~tci; sub = ~tsub;
        wait_done(seen, nb);
        if (seen) begin
            check("busy_len", nb, 8);
            @(negedge hz100);
            check("done_pulse", done, 0);
        end
    endtask

    initial begin
        bit seen;
        int nb;
        int t1;
        int t2;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_co", co, 0);
        check("rst_ovf", ovf, 0);
        @(negedge hz100);
        reset = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b0, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        // start pulsed on the third busy cycle must be ignored
        @(negedge hz100);
        a = 8'h12; b = 8'h34; ci = 1'b0; sub = 1'b0; start = 1'b1;
        sb.push_back(model(8'h12, 8'h34, 1'b0, 1'b0));
        @(negedge hz100);
        start = 1'b0;
        @(negedge hz100);
        @(negedge hz100);
        a = 8'hAA; b = 8'hBB; ci = 1'b1; sub = 1'b1; start = 1'b1;
        @(negedge hz100);
        start = 1'b0;
        wait_done(seen, nb);
        repeat (12) @(negedge hz100);
        check("ignore_idle", busy, 0);

        // back-to-back: start held through DONE
        @(negedge hz100);
        a = 8'h01; b = 8'h02; ci = 1'b0; sub = 1'b0; start = 1'b1;
        sb.push_back(model(8'h01, 8'h02, 1'b0, 1'b0));
        @(negedge hz100);
        a = 8'hC8; b = 8'h64; ci = 1'b1; sub = 1'b1;
        sb.push_back(model(8'hC8, 8'h64, 1'b1, 1'b1));
        wait_done(seen, nb);
        t1 = cyc;
        @(negedge hz100);
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(seen, nb);
        t2 = cyc;
        check("b2b_spacing", t2 - t1, 9);
        @(negedge hz100);

        // reset in the middle of RUN
        @(negedge hz100);
        a = 8'h33; b = 8'h44; ci = 1'b0; sub = 1'b0; start = 1'b1;
        sb.push_back(model(8'h33, 8'h44, 1'b0, 1'b0));
        @(negedge hz100);
        start = 1'b0;
        @(negedge hz100);
        @(negedge hz100);
        #2;
        reset = 1'b0;
        sb.delete();
        last_sum = '0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_co", co, 0);
        check("mid_rst_ovf", ovf, 0);
        repeat (3) @(negedge hz100);
        reset = 1'b1;
        repeat (10) @(negedge hz100);
        check("no_done_after_abort", done, 0);
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);

        // WIDTH=1 instance
        @(negedge hz100);
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
        @(negedge hz100);
        start1 = 1'b0;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done1) begin
                seen = 1'b1;
                break;
            end
            if (busy1) nb++;
            @(negedge hz100);
        end
        check("w1_seen", seen, 1);
        check("w1_busy_len", nb, 1);
        check("w1_sum", sum1, 1);
        check("w1_co", co1, 1);
        check("w1_ovf", ovf1, 0);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
